// File: rtl/ksa_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ksa_pkg : shared state encoding and default widths for the key-search sequencer
// Revision: 1.0
// -----------------------------------------------------------------------------
package ksa_pkg;

   localparam int KSA_ADDR_W = 8;
   localparam int KSA_DATA_W = 8;
   localparam int KSA_KEY_W  = 24;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      WAIT  = 3'd2,
      ACK   = 3'd3,
      DONE  = 3'd4,
      ERROR = 3'd5
   } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/ksa_mem_mux.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ksa_mem_mux : one-hot gated N-way mux of s_memory address/data/wren; all-zero without grant
// Revision: 1.0
// -----------------------------------------------------------------------------
module ksa_mem_mux
   import ksa_pkg::*;
#(
   parameter int N_TASKS = 3,
   parameter int ADDR_W  = KSA_ADDR_W,
   parameter int DATA_W  = KSA_DATA_W
) (
   input  logic [N_TASKS-1:0]        grant,
   input  logic [N_TASKS*ADDR_W-1:0] task_addr,
   input  logic [N_TASKS*DATA_W-1:0] task_wdata,
   input  logic [N_TASKS-1:0]        task_wren,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_data_write,
   output logic                      mem_wren
);

   // AND-OR structure: with a one-hot (or empty) grant only one term can be non-zero.
   always_comb begin
      mem_addr       = '0;
      mem_data_write = '0;
      mem_wren       = 1'b0;
      for (int k = 0; k < N_TASKS; k++) begin
         if (grant[k]) begin
            mem_addr       = mem_addr | task_addr[k*ADDR_W +: ADDR_W];
            mem_data_write = mem_data_write | task_wdata[k*DATA_W +: DATA_W];
            mem_wren       = mem_wren | task_wren[k];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ksa_task_scheduler.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ksa_task_scheduler : runs the RC4 task FSMs in order and owns s_memory arbitration
// Revision: 1.0
// -----------------------------------------------------------------------------
module ksa_task_scheduler
   import ksa_pkg::*;
#(
   parameter int N_TASKS        = 3,
   parameter int ADDR_W         = KSA_ADDR_W,
   parameter int DATA_W         = KSA_DATA_W,
   parameter int KEY_W          = KSA_KEY_W,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      done_ack,
   input  logic [KEY_W-1:0]          secret_key,
   output logic                      done,
   output logic                      error,
   output logic                      busy,
   output logic [KEY_W-1:0]          task_key,
   output logic [N_TASKS-1:0]        task_start,
   input  logic [N_TASKS-1:0]        task_done,
   output logic [N_TASKS-1:0]        task_done_ack,
   input  logic [N_TASKS*ADDR_W-1:0] task_addr,
   input  logic [N_TASKS*DATA_W-1:0] task_wdata,
   input  logic [N_TASKS-1:0]        task_wren,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_data_write,
   output logic                      mem_wren
);

   localparam int IDX_W = (N_TASKS > 1) ? $clog2(N_TASKS) : 1;
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TASKS - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   sched_state_t       state;
   logic [IDX_W-1:0]   idx;
   logic [TMR_W-1:0]   timer;
   logic [N_TASKS-1:0] grant;

   always_comb begin
      grant = '0;
      if (state == START || state == WAIT) grant[idx] = 1'b1;
   end

   // Pulse outputs are loaded on the edge that enters START/ACK so they line up with the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         idx           <= '0;
         timer         <= '0;
         task_key      <= '0;
         task_start    <= '0;
         task_done_ack <= '0;
         done          <= 1'b0;
         error         <= 1'b0;
         busy          <= 1'b0;
      end else begin
         task_start    <= '0;
         task_done_ack <= '0;
         case (state)
            IDLE: begin
               if (start) begin
                  task_key      <= secret_key;
                  idx           <= '0;
                  task_start[0] <= 1'b1;
                  busy          <= 1'b1;
                  state         <= START;
               end
            end
            START: begin
               timer <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (task_done[idx]) begin
                  task_done_ack[idx] <= 1'b1;
                  state              <= ACK;
               end else if (timer == TMR_LAST) begin
                  error <= 1'b1;
                  state <= ERROR;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            ACK: begin
               if (idx == LAST_IDX) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  idx                            <= idx + IDX_W'(1);
                  task_start[idx + IDX_W'(1)]    <= 1'b1;
                  state                          <= START;
               end
            end
            DONE: begin
               if (done_ack) begin
                  done  <= 1'b0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            ERROR: begin
               if (done_ack) begin
                  error <= 1'b0;
                  busy  <= 1'b0;
                  idx   <= '0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   ksa_mem_mux #(
      .N_TASKS (N_TASKS),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W)
   ) u_mem_mux (
      .grant          (grant),
      .task_addr      (task_addr),
      .task_wdata     (task_wdata),
      .task_wren      (task_wren),
      .mem_addr       (mem_addr),
      .mem_data_write (mem_data_write),
      .mem_wren       (mem_wren)
   );

endmodule
`default_nettype wire
